// File: rtl/program_loader.sv
// Streams words from a valid/ready source into program memory at consecutive
// addresses, holding Busy so fetch stays off memory, with word count and XOR sum.
module program_loader #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [AddrWidth-1:0] BaseAddr,
  input  logic [AddrWidth:0]   Length,
  input  logic [DataWidth-1:0] DIn,
  input  logic                 DIn_Valid,
  output logic                 DIn_Ready,
  output logic [AddrWidth-1:0] MEM_Addr,
  output logic [DataWidth-1:0] MEM_DOut,
  output logic                 MEM_WR_N,
  output logic                 Busy,
  output logic                 Done,
  output logic [AddrWidth:0]   Count,
  output logic [DataWidth-1:0] Checksum
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
  localparam logic [AddrWidth:0]   CntOne  = (AddrWidth + 1)'(1);
  localparam logic [AddrWidth:0]   CntZero = '0;

  state_t state;
  state_t state_next;

  logic [AddrWidth:0]   remaining;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (Start)
          state_next = (Length == CntZero) ? DONE : ACCEPT;
      end
      ACCEPT: begin
        if (DIn_Valid) state_next = WRITE;
      end
      WRITE: begin
        state_next = (remaining == CntOne) ? DONE : ACCEPT;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr      <= '0;
      data      <= '0;
      remaining <= '0;
      Count     <= '0;
      Checksum  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            addr      <= BaseAddr;
            remaining <= Length;
            Count     <= '0;
            Checksum  <= '0;
          end
        end
        ACCEPT: begin
          if (DIn_Valid) begin
            data     <= DIn;
            Checksum <= Checksum ^ DIn;
          end
        end
        WRITE: begin
          addr      <= addr + AddrOne;
          Count     <= Count + CntOne;
          remaining <= remaining - CntOne;
        end
        default: ;
      endcase
    end
  end

  // Every output is a decode of registered state; nothing passes straight through.
  assign DIn_Ready = (state == ACCEPT);
  assign MEM_WR_N  = (state != WRITE);
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);
  assign MEM_Addr  = addr;
  assign MEM_DOut  = data;

endmodule
